// File: rtl/packet_scheduler.sv
// Purpose : picks which packet occupies each 32-pixel slot of a data island.
// Latency : grant/packet_type appear 1 cycle after a decision cycle (counter==0).
// Backpress: none; requests are latched as pending flags, a lost sample sets a sticky flag.
//
// Ports
//   clk_pixel          pixel clock, rising edge
//   reset              synchronous active-high reset
//   island_start       pulse: blanking allows an island to begin (ignored while sending)
//   frame_start        pulse: request AVI and Audio InfoFrames
//   acr_req            pulse: Audio Clock Regeneration packet due
//   sample_req         pulse: one Audio Sample packet ready
//   data_island_period high while a slot is being transmitted
//   packet_type        HB0 of the current slot, held for the whole slot
//   counter            pixel index inside the slot, 0..31
//   packet_ack         one-hot grant pulse {audio_if, avi_if, acr, sample}
//   sample_overflow    sticky: a sample request was dropped
//
// Build option: define PACKET_SCHEDULER_NULL_FILL_EN to fill empty slots with NULL
// packets so every island is MAX_PACKETS slots long; otherwise the island ends as
// soon as nothing is pending.

module packet_scheduler #(
  parameter int MAX_PACKETS = 3  // slots per island, 1..7
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic       island_start,
  input  logic       frame_start,
  input  logic       acr_req,
  input  logic       sample_req,
  output logic       data_island_period,
  output logic [7:0] packet_type,
  output logic [4:0] counter,
  output logic [3:0] packet_ack,
  output logic       sample_overflow
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [3:0] MAX_P = 4'(MAX_PACKETS);

`ifdef PACKET_SCHEDULER_NULL_FILL_EN
  localparam logic NULL_FILL = 1'b1;
`else
  localparam logic NULL_FILL = 1'b0;
`endif

  localparam logic [7:0] TYPE_SAMPLE   = 8'h02;
  localparam logic [7:0] TYPE_ACR      = 8'h01;
  localparam logic [7:0] TYPE_AVI_IF   = 8'h82;
  localparam logic [7:0] TYPE_AUDIO_IF = 8'h84;
  localparam logic [7:0] TYPE_NULL     = 8'h00;

  logic [0:0] state;
  logic [2:0] slot_cnt;   // index of the slot currently on the wire
  logic [3:0] pend;       // {audio_if, avi_if, acr, sample}

  logic       last_pixel;
  logic       more_slots;
  logic       decision;
  logic       start_slot;
  logic [3:0] grant;
  logic [7:0] grant_type;
  logic [3:0] req_set;

  assign last_pixel = (state == SEND) && (counter == 5'd31);
  assign more_slots = (({1'b0, slot_cnt} + 4'd1) < MAX_P);

  // A decision either opens an island or chooses the content of the next slot.
  assign decision = ((state == IDLE) && island_start) || (last_pixel && more_slots);

  // Fixed priority over the flags as they stand at the start of the decision cycle.
  always_comb begin
    grant      = 4'b0000;
    grant_type = TYPE_NULL;
    if (decision) begin
      if (pend[0]) begin
        grant      = 4'b0001;
        grant_type = TYPE_SAMPLE;
      end else if (pend[1]) begin
        grant      = 4'b0010;
        grant_type = TYPE_ACR;
      end else if (pend[2]) begin
        grant      = 4'b0100;
        grant_type = TYPE_AVI_IF;
      end else if (pend[3]) begin
        grant      = 4'b1000;
        grant_type = TYPE_AUDIO_IF;
      end
    end
  end

  // Without NULL fill an empty decision produces no slot at all.
  assign start_slot = decision && ((|grant) || NULL_FILL);

  assign req_set = {frame_start, frame_start, acr_req, sample_req};

  assign data_island_period = (state == SEND);

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state           <= IDLE;
      counter         <= 5'd0;
      slot_cnt        <= 3'd0;
      packet_type     <= TYPE_NULL;
      packet_ack      <= 4'b0000;
      pend            <= 4'b0000;
      sample_overflow <= 1'b0;
    end else begin
      packet_ack <= 4'b0000;

      if (start_slot) begin
        state       <= SEND;
        counter     <= 5'd0;
        packet_type <= grant_type;
        packet_ack  <= grant;
        slot_cnt    <= (state == IDLE) ? 3'd0 : slot_cnt + 3'd1;
      end else if (state == SEND) begin
        if (last_pixel) begin
          // Either the island is full or nothing is left to send.
          state       <= IDLE;
          counter     <= 5'd0;
          packet_type <= TYPE_NULL;
        end else begin
          counter <= counter + 5'd1;
        end
      end

      // Clearing before setting lets a request in the grant cycle stay pending.
      pend <= (pend & ~grant) | req_set;

      if (sample_req && pend[0] && !grant[0]) begin
        sample_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_packet_scheduler.sv
module tb_packet_scheduler;

  localparam int MAXP = 3;
`ifdef PACKET_SCHEDULER_NULL_FILL_EN
  localparam bit NULL_FILL = 1'b1;
`else
  localparam bit NULL_FILL = 1'b0;
`endif

  logic       clk_pixel    = 1'b0;
  logic       reset        = 1'b1;
  logic       island_start = 1'b0;
  logic       frame_start  = 1'b0;
  logic       acr_req      = 1'b0;
  logic       sample_req   = 1'b0;
  logic       data_island_period;
  logic [7:0] packet_type;
  logic [4:0] counter;
  logic [3:0] packet_ack;
  logic       sample_overflow;

  int errors = 0;
  int checks = 0;

  packet_scheduler #(.MAX_PACKETS(MAXP)) dut (
    .clk_pixel          (clk_pixel),
    .reset              (reset),
    .island_start       (island_start),
    .frame_start        (frame_start),
    .acr_req            (acr_req),
    .sample_req         (sample_req),
    .data_island_period (data_island_period),
    .packet_type        (packet_type),
    .counter            (counter),
    .packet_ack         (packet_ack),
    .sample_overflow    (sample_overflow)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    reset = 1'b0;
  endtask

  // Watches one island: length, per-slot type/ack, and any ack off slot start or
  // type change inside a slot. Optionally pokes island_start at counter 10 of slot 0.
  task automatic run_island(input bit poke, output int len, output logic [23:0] types,
                            output logic [11:0] acks, output int stray);
    int         nslots;
    logic [7:0] cur;
    len = 0; types = '0; acks = '0; stray = 0; nslots = 0; cur = 8'h00;
    for (int i = 0; i < 140; i++) begin
      island_start = 1'b0;
      if (data_island_period) begin
        len++;
        if (counter == 5'd0) begin
          if (nslots < 3) begin
            types[nslots*8 +: 8] = packet_type;
            acks[nslots*4 +: 4]  = packet_ack;
          end
          cur = packet_type;
          nslots++;
        end else if (packet_type !== cur) begin
          stray++;
        end
        if (poke && nslots == 1 && counter == 5'd10) island_start = 1'b1;
      end
      if (packet_ack != 4'b0000 && !(data_island_period && counter == 5'd0)) stray++;
      tick;
    end
    island_start = 1'b0;
  endtask

  // ---------------- reference model (slot timeline arithmetic) ----------------
  bit         m_pend[4];
  bit         m_ovf;
  bit         m_act;
  int         m_t0, m_now, m_nslot;
  logic [7:0] m_type;
  logic [3:0] m_ack;

  function automatic logic [7:0] type_code(input int k);
    case (k)
      0:       return 8'h02;
      1:       return 8'h01;
      2:       return 8'h82;
      default: return 8'h84;
    endcase
  endfunction

  task automatic model_step(input bit rst, input bit ist, input bit fs, input bit ar, input bit sr);
    bit dec, ending;
    int g, pos;
    dec = 0; ending = 0; g = -1;
    pos = m_now - m_t0;
    if (!m_act) dec = ist;
    else if (pos % 32 == 31) begin
      if (m_nslot < MAXP) dec = 1; else ending = 1;
    end
    if (dec) for (int k = 3; k >= 0; k--) if (m_pend[k]) g = k;
    m_ack = 4'h0;
    if (rst) begin
      for (int k = 0; k < 4; k++) m_pend[k] = 0;
      m_ovf = 0; m_act = 0; m_type = 8'h00; m_nslot = 0;
    end else begin
      if (dec && (g >= 0 || NULL_FILL)) begin
        if (!m_act) begin m_act = 1; m_t0 = m_now + 1; m_nslot = 1; end
        else m_nslot++;
        if (g >= 0) begin
          m_type = type_code(g);
          m_ack  = 4'(1 << g);
        end else begin
          m_type = 8'h00;
        end
      end else if (dec || ending) begin
        m_act = 0;
      end
      if (!m_act) m_type = 8'h00;
      if (sr && m_pend[0] && g != 0) m_ovf = 1;
      if (g >= 0) m_pend[g] = 0;
      if (sr) m_pend[0] = 1;
      if (ar) m_pend[1] = 1;
      if (fs) begin m_pend[2] = 1; m_pend[3] = 1; end
    end
    m_now++;
  endtask

  typedef struct {
    bit          s, a, f;
    int          exp_len;
    logic [23:0] exp_types;  // {slot2, slot1, slot0}
    logic [11:0] exp_acks;   // {slot2, slot1, slot0}
  } vec_t;

  vec_t vt[5];

  initial begin
    int          len, stray;
    logic [23:0] types;
    logic [11:0] acks;
    bit          r, ist, fs, ar, sr;

    vt[0] = '{1'b1, 1'b1, 1'b0, NULL_FILL ? 96 : 64, 24'h00_01_02, 12'h0_2_1};
    vt[1] = '{1'b0, 1'b0, 1'b1, NULL_FILL ? 96 : 64, 24'h00_84_82, 12'h0_8_4};
    vt[2] = '{1'b0, 1'b0, 1'b0, NULL_FILL ? 96 : 0,  24'h00_00_00, 12'h0_0_0};
    vt[3] = '{1'b1, 1'b1, 1'b1, 96,                  24'h82_01_02, 12'h4_2_1};
    vt[4] = '{1'b0, 1'b1, 1'b0, NULL_FILL ? 96 : 32, 24'h00_00_01, 12'h0_0_2};

    // Reset state
    tick;
    check("reset_period", data_island_period, 1'b0);
    check("reset_counter", counter, 5'd0);
    check("reset_type", packet_type, 8'h00);
    check("reset_ack", packet_ack, 4'h0);
    check("reset_ovf", sample_overflow, 1'b0);
    reset = 1'b0;

    // Table of island scenarios
    for (int v = 0; v < 5; v++) begin
      do_reset;
      sample_req = vt[v].s; acr_req = vt[v].a; frame_start = vt[v].f;
      tick;
      sample_req = 1'b0; acr_req = 1'b0; frame_start = 1'b0;
      island_start = 1'b1;
      tick;
      island_start = 1'b0;
      run_island(1'b0, len, types, acks, stray);
      check($sformatf("vec%0d_len", v), len, vt[v].exp_len);
      check($sformatf("vec%0d_types", v), types, vt[v].exp_types);
      check($sformatf("vec%0d_acks", v), acks, vt[v].exp_acks);
      check($sformatf("vec%0d_stray", v), stray, 0);
    end

    // Two sample requests 5 cycles apart with no island -> sticky overflow
    do_reset;
    sample_req = 1'b1; tick; sample_req = 1'b0;
    check("ovf_first_req", sample_overflow, 1'b0);
    repeat (4) tick;
    sample_req = 1'b1; tick; sample_req = 1'b0;
    check("ovf_second_req", sample_overflow, 1'b1);
    repeat (10) tick;
    check("ovf_sticky", sample_overflow, 1'b1);
    reset = 1'b1; tick; reset = 1'b0;
    check("ovf_cleared", sample_overflow, 1'b0);

    // Sample request in the decision cycle while the sample flag is pending
    sample_req = 1'b1; tick; sample_req = 1'b0;
    island_start = 1'b1; tick; island_start = 1'b0;
    check("dec_slot0_type", packet_type, 8'h02);
    check("dec_slot0_ack", packet_ack, 4'b0001);
    repeat (5) tick;
    sample_req = 1'b1; tick; sample_req = 1'b0;
    repeat (25) tick;
    check("dec_counter31", counter, 5'd31);
    sample_req = 1'b1; tick; sample_req = 1'b0;
    check("dec_slot1_type", packet_type, 8'h02);
    check("dec_slot1_ack", packet_ack, 4'b0001);
    check("dec_slot1_ovf", sample_overflow, 1'b0);
    repeat (32) tick;
    check("dec_slot2_period", data_island_period, 1'b1);
    check("dec_slot2_type", packet_type, 8'h02);
    check("dec_slot2_ack", packet_ack, 4'b0001);
    repeat (32) tick;
    check("dec_end_period", data_island_period, 1'b0);
    check("dec_end_ovf", sample_overflow, 1'b0);

    // Reset in the middle of slot 1
    do_reset;
    acr_req = 1'b1; frame_start = 1'b1; tick; acr_req = 1'b0; frame_start = 1'b0;
    island_start = 1'b1; tick; island_start = 1'b0;
    repeat (47) tick;
    check("mid_counter15", counter, 5'd15);
    check("mid_slot1_type", packet_type, 8'h82);
    reset = 1'b1; tick; reset = 1'b0;
    check("mid_rst_period", data_island_period, 1'b0);
    check("mid_rst_counter", counter, 5'd0);
    check("mid_rst_type", packet_type, 8'h00);
    check("mid_rst_ack", packet_ack, 4'h0);
    island_start = 1'b1; tick; island_start = 1'b0;
    check("mid_flags_period", data_island_period, NULL_FILL);
    check("mid_flags_type", packet_type, 8'h00);
    check("mid_flags_ack", packet_ack, 4'h0);

    // island_start during SEND is ignored
    do_reset;
    sample_req = 1'b1; acr_req = 1'b1; tick; sample_req = 1'b0; acr_req = 1'b0;
    island_start = 1'b1; tick; island_start = 1'b0;
    run_island(1'b1, len, types, acks, stray);
    check("poke_len", len, NULL_FILL ? 96 : 64);
    check("poke_acks", acks, 12'h0_2_1);
    check("poke_stray", stray, 0);

    // Randomized traffic against the reference model
    reset = 1'b1;
    model_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick;
    for (int c = 0; c < 4000; c++) begin
      r   = ($urandom_range(0, 499) == 0);
      ist = ($urandom_range(0, 39) == 0);
      fs  = ($urandom_range(0, 149) == 0);
      ar  = ($urandom_range(0, 59) == 0);
      sr  = ($urandom_range(0, 44) == 0);
      reset = r; island_start = ist; frame_start = fs; acr_req = ar; sample_req = sr;
      model_step(r, ist, fs, ar, sr);
      tick;
      check("rnd_period", data_island_period, m_act);
      check("rnd_counter", counter, m_act ? 5'((m_now - m_t0) % 32) : 5'd0);
      check("rnd_type", packet_type, m_type);
      check("rnd_ack", packet_ack, m_ack);
      check("rnd_ovf", sample_overflow, m_ovf);
    end
    reset = 1'b0; island_start = 1'b0; frame_start = 1'b0; acr_req = 1'b0; sample_req = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
